sfp_link_bringup_ctrl: RTL
==========================

SFP_LINK_BRINGUP_CTRL -- requirements
Module: sfp_link_bringup_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 64: cycles the PHY reset is held per attempt (minimum 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000000: per-state wait limit, 100 ms at 50 MHz (minimum 4).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive checker-lock cycles required to declare link up (minimum 1).
REQ-004 SHALL have parameter MAX_RETRY, default 7: failed attempts tolerated before FAULT (range 0..15).
REQ-005 SHALL have port clk_50_clk, input, 1 bit: single clock; all logic is on this clock.
REQ-006 SHALL have port clk_50_reset_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port pll_0_locked, input, 1 bit: system PLL lock, asynchronous level.
REQ-008 SHALL have port xcvr_pll_locked, input, 1 bit: transceiver TX PLL lock, asynchronous level.
REQ-009 SHALL have port reconfig_busy, input, 1 bit: reconfig controller calibrating, asynchronous level.
REQ-010 SHALL have ports tx_ready and rx_ready, input, 1 bit each: PHY reset-controller ready flags, asynchronous levels.
REQ-011 SHALL have port chk_lock, input, 1 bit: pattern checker locked, synchronous level.
REQ-012 SHALL have port chk_err, input, 1 bit: checker bit-error pulse, synchronous, one per cycle.
REQ-013 SHALL have port restart, input, 1 bit: software restart pulse, synchronous.
REQ-014 SHALL have port phy_reset, output, 1 bit: active-high reset request to the custom PHY.
REQ-015 SHALL have ports chk_enable, link_up and link_fault, output, 1 bit each.
REQ-016 SHALL have ports state, output, 3 bits; retry_cnt, output, 4 bits; err_cnt, output, 16 bits.

Function
REQ-017 SHALL pass the five asynchronous levels (REQ-007..REQ-010) through two-flop synchronizers; the FSM acts only on the synchronized copies (2-cycle latency).
REQ-018 SHALL implement states RST_HOLD=0, WAIT_PLL=1, WAIT_CAL=2, WAIT_RDY=3, WAIT_LOCK=4, LINK_UP=5 and FAULT=6, and drive state from registers with the current encoding.
REQ-019 SHALL, in RST_HOLD, drive phy_reset=1 for exactly RST_CYCLES cycles, then enter WAIT_PLL with phy_reset=0.
REQ-020 SHALL advance WAIT_PLL to WAIT_CAL when both synchronized PLL locks are 1.
REQ-021 SHALL advance WAIT_CAL to WAIT_RDY when synchronized reconfig_busy is 0.
REQ-022 SHALL advance WAIT_RDY to WAIT_LOCK when synchronized tx_ready and rx_ready are both 1.
REQ-023 SHALL, in WAIT_LOCK, count consecutive cycles with chk_lock=1, clearing the count on any chk_lock=0, and enter LINK_UP when the count reaches STABLE_CYCLES.
REQ-024 SHALL drive chk_enable=1 only in WAIT_LOCK and LINK_UP, and link_up=1 only in LINK_UP; all outputs are registered.
REQ-025 SHALL clear a per-state timer on entry to each wait state (WAIT_PLL..WAIT_LOCK); when it reaches TIMEOUT_CYCLES-1, the attempt SHALL fail.
REQ-026 SHALL, on a failed attempt, enter FAULT if retry_cnt==MAX_RETRY; otherwise SHALL increment retry_cnt and enter RST_HOLD.
REQ-027 SHALL give the advance condition priority over timeout when both occur in the same cycle.
REQ-028 SHALL, in LINK_UP, increment err_cnt on each chk_err, saturating at 0xFFFF; chk_err SHALL be ignored in all other states.
REQ-029 SHALL, in LINK_UP, treat loss of either PLL lock, tx_ready, rx_ready or chk_lock as link loss; it SHALL enter RST_HOLD with retry_cnt cleared and err_cnt retained.
REQ-030 SHALL, in FAULT, hold phy_reset=1 and link_fault=1 until restart.
REQ-031 SHALL, on restart in any state, enter RST_HOLD next cycle, clear retry_cnt, err_cnt and link_fault; restart SHALL take priority over every other event.

Reset
REQ-032 SHALL, while clk_50_reset_reset=1, force state=RST_HOLD, phy_reset=1, chk_enable=0, link_up=0, link_fault=0, retry_cnt=0, err_cnt=0, and clear all timers and synchronizers.
REQ-033 SHALL, after reset deasserts, restart RST_HOLD timing from zero; reset asserted mid-operation SHALL abort any state immediately.

Verification (RST_CYCLES=4, TIMEOUT_CYCLES=16, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-034 SHALL cover nominal bring-up: all ready inputs=1, busy=0, chk_lock=1 -> phy_reset high 4 cycles, link_up=1 after 8 lock cycles, state=5, retry_cnt=0.
REQ-035 SHALL cover a lock glitch: chk_lock low 1 cycle after 7 lock cycles in WAIT_LOCK -> stable count restarts; link_up only after 8 further consecutive lock cycles.
REQ-036 SHALL cover retry exhaustion: xcvr_pll_locked held 0 -> three timeouts, retry_cnt=2, state=6, link_fault=1, phy_reset=1.
REQ-037 SHALL cover restart: restart pulse in FAULT -> state=0 next cycle, retry_cnt=0, link_fault=0; normal bring-up follows.
REQ-038 SHALL cover error saturation: 70000 chk_err pulses in LINK_UP -> err_cnt=0xFFFF; then rx_ready dropped -> state=0 with err_cnt still 0xFFFF.
REQ-039 SHALL cover a same-cycle event: synchronized tx_ready/rx_ready rise on the timeout cycle of WAIT_RDY -> enters WAIT_LOCK, retry_cnt unchanged.

Source files
------------

// File: rtl/sfp_link_bringup_ctrl.sv
// SFP link bring-up sequencer: PHY reset, PLL/calibration/ready waits, checker lock
// qualification, bounded retries with fault latch, and saturating link error count.
module sfp_link_bringup_ctrl #(
   parameter int RST_CYCLES     = 64,
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRY      = 7
) (
   input  logic        clk_50_clk,
   input  logic        clk_50_reset_reset,
   input  logic        pll_0_locked,
   input  logic        xcvr_pll_locked,
   input  logic        reconfig_busy,
   input  logic        tx_ready,
   input  logic        rx_ready,
   input  logic        chk_lock,
   input  logic        chk_err,
   input  logic        restart,
   output logic        phy_reset,
   output logic        chk_enable,
   output logic        link_up,
   output logic        link_fault,
   output logic [2:0]  state,
   output logic [3:0]  retry_cnt,
   output logic [15:0] err_cnt
);

   localparam int TMAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
   localparam int TW   = $clog2(TMAX);
   localparam int SW   = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [2:0] {
      RST_HOLD  = 3'd0,
      WAIT_PLL  = 3'd1,
      WAIT_CAL  = 3'd2,
      WAIT_RDY  = 3'd3,
      WAIT_LOCK = 3'd4,
      LINK_UP   = 3'd5,
      FAULT     = 3'd6
   } state_t;

   state_t        state_q, state_nx;
   logic [TW-1:0] tmr_q, tmr_nx;
   logic [SW-1:0] scnt_q, scnt_nx;
   logic [3:0]    retry_nx;
   logic [15:0]   err_nx;
   logic [4:0]    meta_q, sync_q;
   logic          fail, tmo, pll_ok, cal_done, rdy;

   // Bit order: {pll_0, xcvr_pll, reconfig_busy, tx_ready, rx_ready}
   always_ff @(posedge clk_50_clk or posedge clk_50_reset_reset) begin
      if (clk_50_reset_reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {pll_0_locked, xcvr_pll_locked, reconfig_busy, tx_ready, rx_ready};
         sync_q <= meta_q;
      end
   end

   assign pll_ok   = sync_q[4] & sync_q[3];
   assign cal_done = ~sync_q[2];
   assign rdy      = sync_q[1] & sync_q[0];
   assign tmo      = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nx = state_q;
      tmr_nx   = tmr_q;
      scnt_nx  = '0;
      retry_nx = retry_cnt;
      err_nx   = err_cnt;
      fail     = 1'b0;
      case (state_q)
         RST_HOLD: begin
            tmr_nx = tmr_q + 1'b1;
            if (tmr_q == TW'(RST_CYCLES - 1)) state_nx = WAIT_PLL;
         end
         WAIT_PLL: begin
            tmr_nx = tmr_q + 1'b1;
            if (pll_ok) state_nx = WAIT_CAL;
            else if (tmo) fail = 1'b1;
         end
         WAIT_CAL: begin
            tmr_nx = tmr_q + 1'b1;
            if (cal_done) state_nx = WAIT_RDY;
            else if (tmo) fail = 1'b1;
         end
         WAIT_RDY: begin
            tmr_nx = tmr_q + 1'b1;
            if (rdy) state_nx = WAIT_LOCK;
            else if (tmo) fail = 1'b1;
         end
         WAIT_LOCK: begin
            tmr_nx = tmr_q + 1'b1;
            if (chk_lock) scnt_nx = scnt_q + 1'b1;
            if (chk_lock && scnt_q == SW'(STABLE_CYCLES - 1)) state_nx = LINK_UP;
            else if (tmo) fail = 1'b1;
         end
         LINK_UP: begin
            if (chk_err && err_cnt != 16'hFFFF) err_nx = err_cnt + 16'd1;
            if (!(pll_ok && rdy && chk_lock)) begin
               state_nx = RST_HOLD;
               retry_nx = '0;
            end
         end
         FAULT:   state_nx = FAULT;
         default: state_nx = RST_HOLD;
      endcase
      if (fail) begin
         if (retry_cnt == 4'(MAX_RETRY)) state_nx = FAULT;
         else begin
            state_nx = RST_HOLD;
            retry_nx = retry_cnt + 4'd1;
         end
      end
      if (restart) begin
         state_nx = RST_HOLD;
         retry_nx = '0;
         err_nx   = '0;
      end
      // Every state entry (including a restart into RST_HOLD) times from zero
      if (state_nx != state_q || restart) tmr_nx = '0;
      if (state_nx != WAIT_LOCK) scnt_nx = '0;
   end

   always_ff @(posedge clk_50_clk or posedge clk_50_reset_reset) begin
      if (clk_50_reset_reset) begin
         state_q    <= RST_HOLD;
         tmr_q      <= '0;
         scnt_q     <= '0;
         retry_cnt  <= '0;
         err_cnt    <= '0;
         phy_reset  <= 1'b1;
         chk_enable <= 1'b0;
         link_up    <= 1'b0;
         link_fault <= 1'b0;
      end else begin
         state_q    <= state_nx;
         tmr_q      <= tmr_nx;
         scnt_q     <= scnt_nx;
         retry_cnt  <= retry_nx;
         err_cnt    <= err_nx;
         phy_reset  <= (state_nx == RST_HOLD) || (state_nx == FAULT);
         chk_enable <= (state_nx == WAIT_LOCK) || (state_nx == LINK_UP);
         link_up    <= (state_nx == LINK_UP);
         link_fault <= (state_nx == FAULT);
      end
   end

   assign state = state_q;

endmodule
